// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Decimal digit count of 2^width-1; 2^width is never a power of ten,
  // so floor(width*log10(2))+1 is exact.
  function automatic int min_bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is shifted.
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Pre-shift correction so the doubled digit carries into the next decade.
  always_comb begin
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a start/ready/done handshake and a glitch-free registered result.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be at least 1");
  end
  if (DIGITS < min_bcd_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small to hold 2^WIDTH-1");
  end

  state_t            r_state;
  logic [SW-1:0]     r_sr;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bcd;
  logic              r_done;

  logic [SW-1:0]     w_adj;
  logic [SW-1:0]     w_next;

  // BCD digits sit above the binary part; the binary bits pass through unadjusted.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_sr[WIDTH + 4*k +: 4]),
      .o_digit (w_adj[WIDTH + 4*k +: 4])
    );
  end
  assign w_adj[WIDTH-1:0] = r_sr[WIDTH-1:0];
  assign w_next           = {w_adj[SW-2:0], 1'b0};

  // Handshake FSM with shift register, bit counter and registered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr    <= {{BW{1'b0}}, bin};
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_sr <= w_next;
          if (r_cnt == '0) begin
            r_bcd   <= w_next[SW-1:WIDTH];
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign done  = r_done;
  assign bcd   = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=16, DIGITS=5) using an
// expected-result queue filled at launch and drained on each done pulse.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                ready;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .ready   (ready),
    .done    (done),
    .bcd     (bcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with ready=1; returns at the negedge after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] v, input logic [4*DIGITS-1:0] e);
    start = 1'b1;
    bin   = v;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge just after the accepting edge; returns one cycle after done.
  task automatic wait_done(input string tag, input int inject_at, input bit scramble,
                           output int done_cyc);
    int n = 0;
    bit busy_ok = 1'b1;
    logic [4*DIGITS-1:0] e = 'x;
    while (done !== 1'b1 && n < 40) begin
      if (ready !== 1'b0) busy_ok = 1'b0;
      if (n == inject_at) begin
        start = 1'b1;
        bin   = 16'd42;
      end else if (n == inject_at + 1) begin
        start = 1'b0;
      end
      if (scramble) bin = 16'($urandom);
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    check({tag, " latency"}, n, 16);
    check({tag, " ready low while busy"}, 32'(busy_ok), 32'd1);
    check({tag, " ready at done"}, 32'(ready), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, " bcd"}, 32'(bcd), 32'(e));
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  // Idle window: no done pulse, ready stays high, bcd holds the given value.
  task automatic idle_check(input string tag, input int cycles, input logic [4*DIGITS-1:0] hold);
    bit ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || ready !== 1'b1 || bcd !== hold) ok = 1'b0;
    end
    check({tag, " idle stable"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int c1, c2, cx;
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    repeat (2) @(negedge clk);
    check("in reset ready", 32'(ready), 32'd1);
    check("in reset done", 32'(done), 32'd0);
    check("in reset bcd", 32'(bcd), 32'h00000);
    reset_n = 1'b1;
    @(negedge clk);
    check("post reset ready", 32'(ready), 32'd1);
    check("post reset bcd", 32'(bcd), 32'h00000);
    idle_check("after reset", 5, 20'h00000);

    launch(16'd0, 20'h00000);
    wait_done("conv 0", -10, 1'b0, cx);
    launch(16'd1234, 20'h01234);
    wait_done("conv 1234", -10, 1'b0, cx);
    idle_check("hold 1234", 3, 20'h01234);
    launch(16'd65535, 20'h65535);
    wait_done("conv 65535", -10, 1'b0, cx);

    launch(16'd999, 20'h00999);
    wait_done("busy 999", 5, 1'b0, cx);
    idle_check("busy no second done", 20, 20'h00999);

    launch(16'd40960, 20'h40960);
    wait_done("stable 40960", -10, 1'b1, cx);
    bin = '0;

    // Back-to-back: start held high, second value accepted on the done cycle.
    start = 1'b1;
    bin   = 16'd9;
    exp_q.push_back(20'h00009);
    exp_q.push_back(20'h00010);
    @(negedge clk);
    bin = 16'd10;
    wait_done("b2b 9", -10, 1'b0, c1);
    start = 1'b0;
    wait_done("b2b 10", -10, 1'b0, c2);
    check("b2b spacing", c2 - c1, 17);

    // Abort a conversion with an asynchronous mid-cycle reset.
    start = 1'b1;
    bin   = 16'd5555;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort bcd", 32'(bcd), 32'h00000);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("abort no done", 20, 20'h00000);
    launch(16'd77, 20'h00077);
    wait_done("after abort 77", -10, 1'b0, cx);
    check("queue drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns an unsigned binary value into packed 4-bit decimal digits. It sits directly upstream of the per-digit hex display drivers: each 4-bit digit of `bcd` feeds one display driver's `data` input, so counters and sums show in decimal on the HEX displays. A start/ready/done handshake lets any producer request a conversion and latch the result.

## Interface
- `WIDTH`, default 16: bit width of the binary input (≥1).
- `DIGITS`, default 5: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1; an elaboration-time check fails otherwise.
- `clk`  input  1: single clock; all state changes on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset; asserting it forces reset values immediately, independent of `clk`.
- `start`  input  1: conversion request; sampled only on a rising edge while `ready`=1.
- `bin`  input  WIDTH: unsigned value to convert; captured on the edge that accepts `start`.
- `ready`  output  1: high when idle and able to accept `start`.
- `done`  output  1: one-cycle pulse; `bcd` holds the new result from this cycle on.
- `bcd`  output  4*DIGITS: packed result; digit k (ones = 0) occupies bits [4k+3:4k]; each digit 0–9.

## Operation
- Two states: IDLE and SHIFT. Reset → IDLE.
- IDLE, `start`=1 at an edge: capture `bin` into a shift register of width 4*DIGITS + WIDTH (BCD part cleared to 0); load bit counter with WIDTH−1; go to SHIFT.
- IDLE, `start`=0: hold; `bcd` keeps the last result.
- SHIFT, each edge: every BCD digit ≥5 gets +3; then the whole register shifts left by 1. Counter decrements.
- SHIFT, edge where counter = 0: perform the final adjust+shift, write the BCD part to `bcd`, pulse `done`, and return to IDLE.
- `start` during SHIFT: ignored, with no queuing. `bin` changes after capture have no effect.
- Arithmetic: the add-3 is per digit on 4-bit fields; a digit never exceeds 4 bits before the shift (max 9+3=12). No carries between digits except through the shift.
- Reset values: `ready`=1, `done`=0, `bcd`=0, internal shift register and counter = 0.
- Reset asserted mid-conversion: abort. Outputs take reset values, no `done` pulse, and the partial result is discarded.

## Timing
- `ready` is decoded from state (IDLE). It drops in the cycle after the accepting edge E0.
- Latency: the start is accepted at edge E0; `done`=1 and `bcd` are valid in the cycle following edge E_WIDTH (exactly WIDTH clocks).
- `done` is registered and high for exactly one cycle. `ready` is also 1 in that cycle, so a new `start` can be accepted on the next edge, E_WIDTH+1 (back-to-back throughput of one conversion per WIDTH+1 cycles).
- `bcd` is registered. It changes only at the `done` edge or on reset, so it is glitch-free for downstream display drivers.

## Structure
- Shared package `bcd_pkg`: state enum typedef (IDLE, SHIFT) and a constant function `min_bcd_digits(width)` used for the DIGITS check.
- Sub-module `bcd_digit_adjust`: combinational, 4-bit in/out, returns d+3 when d≥5 and d otherwise. It is instantiated DIGITS times via generate.
- Counter width: $clog2(WIDTH) (min 1).

## Test plan
- Reset then idle: hold `reset_n`=0 for 2 cycles, release → `ready`=1, `done`=0, `bcd`=20'h00000; no change with `start`=0 for 5 cycles.
- Basic conversions (WIDTH=16, DIGITS=5): `bin`=0 → `bcd`=20'h00000; `bin`=1234 → 20'h01234; `bin`=65535 → 20'h65535. Each `done` pulse arrives exactly 16 clocks after the accepting edge and lasts 1 cycle.
- Busy rejection: start with `bin`=999; at clock 5, drive `start`=1 with `bin`=42 → result 20'h00999; only one `done` pulse; `ready`=0 throughout SHIFT.
- Input stability: change `bin` every cycle during the conversion of 40960 → `bcd`=20'h40960.
- Back-to-back: hold `start`=1 with `bin`=9 then 10 → `done` pulses 17 cycles apart; `bcd`=20'h00009 then 20'h00010.
- Reset mid-operation: assert `reset_n`=0 at clock 8 of converting 5555 (asynchronously, mid-cycle) → `bcd`=0, `ready`=1 immediately, and no `done`. A fresh start of 77 then yields 20'h00077.
